note_duration_timer: RTL and testbench

NOTE_DURATION_TIMER -- requirements
Module: note_duration_timer

---
 rtl/note_duration_timer.sv | 169 ++++++++++++++++
 tb/tb_note_duration_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/note_duration_timer.sv
// note_duration_timer: plays one note of (L+1) units of T clocks each,
// producing an articulated gate, a pulse on the last clock of every unit
// and a completion pulse. Note length is counted by a tick counter nested
// in a unit counter, so duration is exact for any L and T.
module note_duration_timer #(
   parameter int LEN_WIDTH   = 5,
   parameter int COUNT_WIDTH = 32,
   parameter int GAP_TICKS   = 250000
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [LEN_WIDTH-1:0]   i_note_len,
   input  logic [1:0]             i_mode,
   input  logic [COUNT_WIDTH-1:0] i_ticks_per_unit,
   input  logic                   i_abort,
   output logic                   o_ready,
   output logic                   o_gate,
   output logic                   o_unit_tick,
   output logic                   o_done
);

   // Width of L+1, and of a full note duration (L+1)*T with no overflow.
   localparam int LW1 = LEN_WIDTH + 1;
   localparam int PW  = LW1 + COUNT_WIDTH;
   localparam logic [PW-1:0] GAP_EXT = PW'(GAP_TICKS);

   localparam logic [1:0] MODE_LEGATO   = 2'b00;
   localparam logic [1:0] MODE_NORMAL   = 2'b01;
   localparam logic [1:0] MODE_STACCATO = 2'b10;
   localparam logic [1:0] MODE_REST     = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t                 state_reg, state_next;
   logic [COUNT_WIDTH-1:0] tick_reg, tick_next;
   logic [LEN_WIDTH-1:0]   unit_reg, unit_next;
   logic [LEN_WIDTH-1:0]   len_reg, len_next;
   logic [1:0]             mode_reg, mode_next;
   logic [COUNT_WIDTH-1:0] t_reg, t_next;
   logic                   first_reg, first_next;
   logic [PW-1:0]          left_reg, left_next;
   logic                   gate_reg, gate_next;
   logic                   done_reg, done_next;

   logic                   unit_end;
   logic                   last_cycle;
   logic [LW1-1:0]         len1;
   logic [LW1-1:0]         half_units;
   logic [LW1-1:0]         s_units;
   logic [LW1-1:0]         next_unit;
   logic [PW-1:0]          t_ext;
   logic [PW-1:0]          pp [0:LEN_WIDTH];
   logic [PW-1:0]          dur;
   logic [PW-1:0]          left_now;

   assign unit_end   = (tick_reg == (t_reg - COUNT_WIDTH'(1)));
   assign last_cycle = unit_end && (unit_reg == len_reg);
   assign len1       = {1'b0, len_reg} + LW1'(1);
   assign half_units = len1 >> 1;
   assign s_units    = (half_units == '0) ? LW1'(1) : half_units;
   assign next_unit  = {1'b0, unit_reg} + LW1'(unit_end);
   assign t_ext      = {{LW1{1'b0}}, t_reg};

   // Shift-add partial products of (L+1)*T; this product only places the
   // articulation gap, the note itself is timed by the nested counters.
   genvar gi;
   generate
      for (gi = 0; gi <= LEN_WIDTH; gi++) begin : g_pp
         assign pp[gi] = len1[gi] ? (t_ext << gi) : '0;
      end
   endgenerate

   // Sum the partial products into the full note duration.
   always_comb begin
      dur = '0;
      for (int i = 0; i <= LEN_WIDTH; i++) begin
         dur = dur + pp[i];
      end
   end

   // Cycles still to play after the current one; seeded on the first cycle.
   assign left_now = first_reg ? (dur - PW'(1)) : left_reg;

   // State and datapath registers; reset aborts any note immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
         tick_reg  <= '0;
         unit_reg  <= '0;
         len_reg   <= '0;
         mode_reg  <= '0;
         t_reg     <= '0;
         first_reg <= 1'b0;
         left_reg  <= '0;
         gate_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         tick_reg  <= tick_next;
         unit_reg  <= unit_next;
         len_reg   <= len_next;
         mode_reg  <= mode_next;
         t_reg     <= t_next;
         first_reg <= first_next;
         left_reg  <= left_next;
         gate_reg  <= gate_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic: accept, count ticks within units, articulate, finish.
   always_comb begin
      state_next = state_reg;
      tick_next  = tick_reg;
      unit_next  = unit_reg;
      len_next   = len_reg;
      mode_next  = mode_reg;
      t_next     = t_reg;
      first_next = 1'b0;
      left_next  = left_reg;
      gate_next  = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start && !i_abort) begin
               state_next = PLAY;
               tick_next  = '0;
               unit_next  = '0;
               len_next   = i_note_len;
               mode_next  = i_mode;
               t_next     = (i_ticks_per_unit == '0) ? COUNT_WIDTH'(1) : i_ticks_per_unit;
               first_next = 1'b1;
               // The first clock of a note always sounds unless it is a rest.
               gate_next  = (i_mode != MODE_REST);
            end
         end
         PLAY: begin
            if (i_abort) begin
               state_next = IDLE;
            end else if (last_cycle) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               tick_next = unit_end ? '0 : (tick_reg + COUNT_WIDTH'(1));
               unit_next = unit_end ? (unit_reg + LEN_WIDTH'(1)) : unit_reg;
               left_next = left_now - PW'(1);
               case (mode_reg)
                  MODE_LEGATO:   gate_next = 1'b1;
                  MODE_NORMAL:   gate_next = (left_now > GAP_EXT);
                  MODE_STACCATO: gate_next = (next_unit < s_units);
                  MODE_REST:     gate_next = 1'b0;
                  default:       gate_next = 1'b0;
               endcase
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_ready     = (state_reg == IDLE);
   assign o_gate      = gate_reg;
   assign o_unit_tick = (state_reg == PLAY) && unit_end;
   assign o_done      = done_reg;

endmodule

// File: tb/tb_note_duration_timer.sv
// Bench for note_duration_timer: each note pushes its per-cycle expected
// outputs into a scoreboard queue, popped and compared on every falling edge.
module tb_note_duration_timer;

   localparam int GAP = 3;

   typedef struct packed {
      logic ready;
      logic gate;
      logic tick;
      logic done;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  note_len;
   logic [1:0]  mode;
   logic [31:0] tpu;
   logic        abort;
   logic        ready;
   logic        gate;
   logic        unit_tick;
   logic        done;

   exp_t        exp_q[$];
   int          n_checks;
   int          n_fail;
   logic        done_due;

   note_duration_timer #(
      .LEN_WIDTH(5),
      .COUNT_WIDTH(32),
      .GAP_TICKS(GAP)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_start(start),
      .i_note_len(note_len),
      .i_mode(mode),
      .i_ticks_per_unit(tpu),
      .i_abort(abort),
      .o_ready(ready),
      .o_gate(gate),
      .o_unit_tick(unit_tick),
      .o_done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp_v);
      end
   endtask

   // Scoreboard: one expected entry per clock, compared mid-cycle.
   always @(negedge clk) begin
      exp_t ev;
      if (exp_q.size() != 0) begin
         ev = exp_q.pop_front();
         check_eq("ready", 32'(ready), 32'(ev.ready));
         check_eq("gate", 32'(gate), 32'(ev.gate));
         check_eq("unit_tick", 32'(unit_tick), 32'(ev.tick));
         check_eq("done", 32'(done), 32'(ev.done));
      end
   end

   task automatic drive(input logic st, input int l, input int md, input int tp, input logic ab, input exp_t e);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      start    = st;
      note_len = 5'(l);
      mode     = 2'(md);
      tpu      = 32'(tp);
      abort    = ab;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.ready = 1'b1;
         e.gate  = 1'b0;
         e.tick  = 1'b0;
         e.done  = done_due;
         drive(1'b0, 0, 0, 0, 1'b0, e);
         done_due = 1'b0;
      end
   endtask

   // Start a note now; abort_k / rst_k (0 = never) cut it at cycle N+k.
   task automatic run_note(input int l, input int md, input int tpu_v, input int abort_k, input int rst_k);
      int   t, d, g, s;
      exp_t e;
      t = (tpu_v == 0) ? 1 : tpu_v;
      d = (l + 1) * t;
      g = (GAP < d - 1) ? GAP : d - 1;
      s = (l + 1) >> 1;
      if (s < 1) s = 1;
      $display("note len=%0d mode=%0d tpu=%0d abort_at=%0d reset_at=%0d", l, md, tpu_v, abort_k, rst_k);
      e.ready = 1'b1;
      e.gate  = 1'b0;
      e.tick  = 1'b0;
      e.done  = done_due;
      drive(1'b1, l, md, tpu_v, 1'b0, e);
      done_due = 1'b0;
      for (int k = 1; k <= d; k++) begin
         e.ready = 1'b0;
         e.done  = 1'b0;
         e.tick  = ((k % t) == 0);
         case (md)
            0:       e.gate = 1'b1;
            1:       e.gate = (k <= d - g);
            2:       e.gate = (((k - 1) / t) < s);
            default: e.gate = 1'b0;
         endcase
         if (k == rst_k) begin
            e.ready = 1'b1;
            e.gate  = 1'b0;
            e.tick  = 1'b0;
            drive(1'b0, 0, 0, 0, 1'b0, e);
            #2;
            rst_n = 1'b0;
            #1;
            check_eq("rst_gate", 32'(gate), 32'd0);
            check_eq("rst_ready", 32'(ready), 32'd1);
            return;
         end
         // Inputs other than abort are scrambled to prove they were latched.
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 9)), (k == abort_k), e);
         if (k == abort_k) return;
      end
      done_due = 1'b1;
   endtask

   initial begin
      exp_t e;
      n_checks = 0;
      n_fail   = 0;
      done_due = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      note_len = '0;
      mode     = '0;
      tpu      = '0;
      abort    = 1'b0;
      #12;
      check_eq("reset_ready", 32'(ready), 32'd1);
      check_eq("reset_gate", 32'(gate), 32'd0);
      check_eq("reset_tick", 32'(unit_tick), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);

      idle(2);
      run_note(2, 0, 4, 0, 0);      // legato L=2 T=4
      idle(1);
      run_note(0, 1, 4, 0, 0);      // normal, gap clipped to D-1
      run_note(2, 1, 4, 0, 0);      // back-to-back normal, full gap
      run_note(3, 2, 4, 0, 0);      // staccato L=3
      run_note(0, 2, 4, 0, 0);      // staccato L=0
      run_note(1, 3, 0, 0, 0);      // rest with T=0 treated as 1
      idle(1);
      run_note(2, 0, 4, 5, 0);      // abort at N+5
      idle(2);

      // Abort in IDLE blocks a simultaneous start.
      $display("idle start with abort");
      e.ready = 1'b1;
      e.gate  = 1'b0;
      e.tick  = 1'b0;
      e.done  = 1'b0;
      drive(1'b1, 2, 0, 4, 1'b1, e);
      idle(2);

      run_note(4, 1, 1, 0, 0);      // normal T=1
      run_note(4, 2, 3, 0, 0);      // staccato odd unit count
      run_note(31, 1, 1, 0, 0);     // maximum length index
      idle(1);
      run_note(2, 0, 4, 0, 6);      // reset mid-note
      run_note(1, 0, 2, 0, 0);      // accepted right after reset release
      idle(3);

      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
